// File: rtl/ext_power_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_power_sequencer_pkg
// Description : Shared types and constants for the external power sequencer:
//               FSM state encoding, sequence direction, OFF output levels
//               and small width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_power_sequencer_pkg;

    // Sequencer states; one domain is in flight at a time
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PU_SW     = 4'd1,
        ST_PU_ACK    = 4'd2,
        ST_PU_SETTLE = 4'd3,
        ST_PU_ISO    = 4'd4,
        ST_PU_RST    = 4'd5,
        ST_PU_CLK    = 4'd6,
        ST_PD_CLK    = 4'd7,
        ST_PD_ISO    = 4'd8,
        ST_PD_RST    = 4'd9,
        ST_PD_SW     = 4'd10,
        ST_PD_ACK    = 4'd11
    } state_e;

    // Sequence direction as seen on target_on_i
    localparam logic c_seq_up   = 1'b1;
    localparam logic c_seq_down = 1'b0;

    // Output levels of a fully powered-down domain
    localparam logic c_off_switch_n     = 1'b1;
    localparam logic c_off_iso_n        = 1'b0;
    localparam logic c_off_rst_n        = 1'b0;
    localparam logic c_off_clkgate_en_n = 1'b0;

    // Width of a domain index; a single domain still gets one bit
    function automatic int cur_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ext_power_sequencer_pkg
`default_nettype wire

// File: rtl/ext_power_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ext_power_sequencer_if
// Description : Control/status bundle between the power sequencer (master)
//               and the software/switch-cell side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ext_power_sequencer_if
    import ext_power_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = 1
);
    localparam int CUR_W = cur_width(NUM_DOMAINS);

    logic [NUM_DOMAINS-1:0] target_on_i;
    logic [NUM_DOMAINS-1:0] switch_ack_ni;
    logic [NUM_DOMAINS-1:0] switch_no;
    logic [NUM_DOMAINS-1:0] iso_no;
    logic [NUM_DOMAINS-1:0] rst_no;
    logic [NUM_DOMAINS-1:0] clkgate_en_no;
    logic [NUM_DOMAINS-1:0] domain_on_o;
    logic                   busy_o;
    logic [CUR_W-1:0]       cur_domain_o;
    logic [NUM_DOMAINS-1:0] err_o;
    logic [NUM_DOMAINS-1:0] err_clr_i;

    modport master (
        input  target_on_i, switch_ack_ni, err_clr_i,
        output switch_no, iso_no, rst_no, clkgate_en_no,
               domain_on_o, busy_o, cur_domain_o, err_o
    );

    modport slave (
        output target_on_i, switch_ack_ni, err_clr_i,
        input  switch_no, iso_no, rst_no, clkgate_en_no,
               domain_on_o, busy_o, cur_domain_o, err_o
    );

endinterface : ext_power_sequencer_if
`default_nettype wire

// File: rtl/ext_power_sequencer_ack_sync.sv
`default_nettype none
// ============================================================================
// Module      : ext_pwr_ack_sync
// Description : N-bit multi-stage flop synchronizer for the asynchronous
//               active-low switch-cell acks. Flops reset to 1 (switch off).
// Revision    : 1.0 - initial release
// ============================================================================
module ext_pwr_ack_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic [WIDTH-1:0] async_i,
    output logic      [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift the raw ack through STAGES flops; reset reads as "switch off"
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '1;
            end
        end else begin
            r_stage[0] <= async_i;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign sync_o = r_stage[STAGES-1];

endmodule : ext_pwr_ack_sync
`default_nettype wire

// File: rtl/ext_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ext_power_sequencer
// Description : Round-robin power-gating sequencer for the external
//               subsystem domains. Drives switch/iso/reset/clock-gate
//               controls one domain at a time and waits on the synchronized
//               switch-cell ack.
//               Optional macro EXT_PWR_SEQ_TIMEOUT_EN adds an ack-wait
//               timeout with sticky per-domain error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_power_sequencer
    import ext_power_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS    = 1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    ext_power_sequencer_if.master  bus
);

    localparam int CUR_W = cur_width(NUM_DOMAINS);
    localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

    state_e                 r_state;
    logic [CUR_W-1:0]       r_cur;
    logic [CUR_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_DOMAINS-1:0] r_switch_n;
    logic [NUM_DOMAINS-1:0] r_iso_n;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic [NUM_DOMAINS-1:0] r_clkgate_en_n;
    logic [NUM_DOMAINS-1:0] r_domain_on;
    logic                   r_busy;
    logic [NUM_DOMAINS-1:0] r_err;

    logic [NUM_DOMAINS-1:0] w_ack_sync_n;
    logic [NUM_DOMAINS-1:0] w_eligible;
    logic                   w_grant_found;
    logic [CUR_W-1:0]       w_grant_idx;

    ext_pwr_ack_sync #(
        .WIDTH  (NUM_DOMAINS),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (bus.switch_ack_ni),
        .sync_o  (w_ack_sync_n)
    );

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
    // A domain in error sits out arbitration until software clears it
    assign w_eligible = (bus.target_on_i ^ r_domain_on) & ~r_err;
    assign bus.err_o  = r_err;
`else
    assign w_eligible = bus.target_on_i ^ r_domain_on;
    assign bus.err_o  = '0;
    logic w_unused_err = ^{bus.err_clr_i, r_err};
`endif

    // Round-robin search starting just after the last served domain
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 1; k <= NUM_DOMAINS; k++) begin
            if (!w_grant_found &&
                w_eligible[CUR_W'((int'(r_ptr) + k) % NUM_DOMAINS)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = CUR_W'((int'(r_ptr) + k) % NUM_DOMAINS);
            end
        end
    end

    // Sequencer FSM with registered per-domain controls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_cur          <= '0;
            r_ptr          <= CUR_W'(NUM_DOMAINS - 1);
            r_cnt          <= '0;
            r_switch_n     <= {NUM_DOMAINS{c_off_switch_n}};
            r_iso_n        <= {NUM_DOMAINS{c_off_iso_n}};
            r_rst_n        <= {NUM_DOMAINS{c_off_rst_n}};
            r_clkgate_en_n <= {NUM_DOMAINS{c_off_clkgate_en_n}};
            r_domain_on    <= '0;
            r_busy         <= 1'b0;
            r_err          <= '0;
        end else begin
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
            // Clear first so a same-cycle timeout set below takes priority
            r_err <= r_err & ~bus.err_clr_i;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        r_cur  <= w_grant_idx;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (bus.target_on_i[w_grant_idx] == c_seq_up) begin
                            r_state <= ST_PU_SW;
                        end else begin
                            r_domain_on[w_grant_idx] <= 1'b0;
                            r_state                  <= ST_PD_CLK;
                        end
                    end
                end
                ST_PU_SW: begin
                    r_switch_n[r_cur] <= 1'b0;
                    r_cnt             <= '0;
                    r_state           <= ST_PU_ACK;
                end
                ST_PU_ACK: begin
                    if (!w_ack_sync_n[r_cur]) begin
                        r_cnt   <= '0;
                        r_state <= ST_PU_SETTLE;
                    end
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err[r_cur]       <= 1'b1;
                        r_switch_n[r_cur]  <= c_off_switch_n;
                        r_domain_on[r_cur] <= 1'b0;
                        r_ptr              <= r_cur;
                        r_busy             <= 1'b0;
                        r_state            <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_PU_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_PU_ISO;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PU_ISO: begin
                    r_iso_n[r_cur] <= 1'b1;
                    r_state        <= ST_PU_RST;
                end
                ST_PU_RST: begin
                    r_rst_n[r_cur] <= 1'b1;
                    r_state        <= ST_PU_CLK;
                end
                ST_PU_CLK: begin
                    r_clkgate_en_n[r_cur] <= 1'b1;
                    r_domain_on[r_cur]    <= 1'b1;
                    r_ptr                 <= r_cur;
                    r_busy                <= 1'b0;
                    r_state               <= ST_IDLE;
                end
                ST_PD_CLK: begin
                    r_clkgate_en_n[r_cur] <= 1'b0;
                    r_state               <= ST_PD_ISO;
                end
                ST_PD_ISO: begin
                    r_iso_n[r_cur] <= 1'b0;
                    r_state        <= ST_PD_RST;
                end
                ST_PD_RST: begin
                    r_rst_n[r_cur] <= 1'b0;
                    r_state        <= ST_PD_SW;
                end
                ST_PD_SW: begin
                    r_switch_n[r_cur] <= 1'b1;
                    r_cnt             <= '0;
                    r_state           <= ST_PD_ACK;
                end
                ST_PD_ACK: begin
                    if (w_ack_sync_n[r_cur]) begin
                        r_ptr   <= r_cur;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err[r_cur]       <= 1'b1;
                        r_switch_n[r_cur]  <= c_off_switch_n;
                        r_domain_on[r_cur] <= 1'b0;
                        r_ptr              <= r_cur;
                        r_busy             <= 1'b0;
                        r_state            <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.switch_no     = r_switch_n;
    assign bus.iso_no        = r_iso_n;
    assign bus.rst_no        = r_rst_n;
    assign bus.clkgate_en_no = r_clkgate_en_n;
    assign bus.domain_on_o   = r_domain_on;
    assign bus.busy_o        = r_busy;
    assign bus.cur_domain_o  = r_cur;

endmodule : ext_power_sequencer
`default_nettype wire

// File: tb/tb_ext_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_power_sequencer
// Description : Directed self-checking bench for ext_power_sequencer (4
//               domains). Switch-cell acks are modelled as switch_no
//               delayed by 15 clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_power_sequencer;

    localparam int N   = 4;
    localparam int DLY = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ext_power_sequencer_if #(.NUM_DOMAINS(N)) bus ();

    ext_power_sequencer #(
        .NUM_DOMAINS    (N),
        .SETTLE_CYCLES  (4),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Ack model: switch_no through a 15-flop delay line, optionally stuck high
    logic [N-1:0] dly [DLY];
    logic [N-1:0] stuck;
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DLY; k++) dly[k] <= '1;
        end else begin
            dly[0] <= bus.switch_no;
            for (int k = 1; k < DLY; k++) dly[k] <= dly[k-1];
        end
    end
    assign bus.switch_ack_ni = dly[DLY-1] | stuck;

    int checks   = 0;
    int failures = 0;
    int t_sw, t_iso, t_rst, t_clk, t_on, t_lo, t_g;
    int nwait;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output int n);
        n = 0;
        while (bus.busy_o !== lvl && n < bound) begin
            tick();
            n++;
        end
    endtask

    // Record the first-change tick of each control of domain d, relative to grant
    task automatic watch(input int d, input int bound);
        logic p_sw, p_iso, p_rst, p_clk, p_on;
        p_sw  = bus.switch_no[d];
        p_iso = bus.iso_no[d];
        p_rst = bus.rst_no[d];
        p_clk = bus.clkgate_en_no[d];
        p_on  = bus.domain_on_o[d];
        t_sw = -1; t_iso = -1; t_rst = -1; t_clk = -1; t_on = -1; t_lo = -1; t_g = -1;
        for (int n = 1; n <= bound; n++) begin
            tick();
            if (t_g < 0 && bus.busy_o === 1'b1) t_g = n;
            if (t_sw  < 0 && bus.switch_no[d]     !== p_sw)  t_sw  = n;
            if (t_iso < 0 && bus.iso_no[d]        !== p_iso) t_iso = n;
            if (t_rst < 0 && bus.rst_no[d]        !== p_rst) t_rst = n;
            if (t_clk < 0 && bus.clkgate_en_no[d] !== p_clk) t_clk = n;
            if (t_on  < 0 && bus.domain_on_o[d]   !== p_on)  t_on  = n;
            if (t_g >= 0 && bus.busy_o === 1'b0) begin
                t_lo = n;
                break;
            end
        end
    endtask

    function automatic int rel(input int t);
        return (t < 0 || t_g < 0) ? -1 : t - t_g;
    endfunction

    task automatic chk_off_all(input string tag);
        chk({tag, "_sw"},   32'(bus.switch_no),     32'hF);
        chk({tag, "_iso"},  32'(bus.iso_no),        32'h0);
        chk({tag, "_rst"},  32'(bus.rst_no),        32'h0);
        chk({tag, "_clk"},  32'(bus.clkgate_en_no), 32'h0);
        chk({tag, "_on"},   32'(bus.domain_on_o),   32'h0);
        chk({tag, "_busy"}, 32'(bus.busy_o),        32'h0);
        chk({tag, "_cur"},  32'(bus.cur_domain_o),  32'h0);
        chk({tag, "_err"},  32'(bus.err_o),         32'h0);
    endtask

    initial begin
        bus.target_on_i = '0;
        bus.err_clr_i   = '0;
        stuck           = '0;
        rst             = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        chk_off_all("reset");

        // Power up domain 0: switch falls at +1, on/iso/rst/clk at 24/25/26
        bus.target_on_i = 4'b0001;
        watch(0, 60);
        chk("up_grant",   32'(t_g),        32'd1);
        chk("up_sw",      32'(rel(t_sw)),  32'd1);
        chk("up_iso",     32'(rel(t_iso)), 32'd24);
        chk("up_rst",     32'(rel(t_rst)), 32'd25);
        chk("up_clk",     32'(rel(t_clk)), 32'd26);
        chk("up_on",      32'(rel(t_on)),  32'd26);
        chk("up_idle",    32'(rel(t_lo)),  32'd26);
        chk("up_on_vec",  32'(bus.domain_on_o), 32'h1);
        chk("up_sw_vec",  32'(bus.switch_no),   32'hE);

        // Power down domain 0: clk/iso/rst/switch on 4 consecutive cycles
        bus.target_on_i = 4'b0000;
        watch(0, 60);
        chk("dn_on",   32'(rel(t_on)),  32'd0);
        chk("dn_clk",  32'(rel(t_clk)), 32'd1);
        chk("dn_iso",  32'(rel(t_iso)), 32'd2);
        chk("dn_rst",  32'(rel(t_rst)), 32'd3);
        chk("dn_sw",   32'(rel(t_sw)),  32'd4);
        // 15 ack delay + 2 sync flops + 1 cycle to leave PD_ACK
        chk("dn_busy_after_sw", 32'(rel(t_lo) - rel(t_sw)), 32'd18);
        chk("dn_sw_vec", 32'(bus.switch_no), 32'hF);

        // Reset in the middle of PU_SETTLE returns everything to OFF at once
        bus.target_on_i = 4'b0001;
        tick();
        chk("rs_busy_grant", 32'(bus.busy_o), 32'h1);
        for (int k = 0; k < 20; k++) tick();
        chk("rs_sw_down", 32'(bus.switch_no), 32'hE);
        chk("rs_not_on",  32'(bus.domain_on_o), 32'h0);
        rst = 1'b1;
        bus.target_on_i = 4'b0000;
        tick();
        chk_off_all("rs_mid");
        rst = 1'b0;

        // All four requested together: served 0,1,2,3 one at a time
        bus.target_on_i = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_busy(1'b1, 10, nwait);
            chk("all_grant_busy", 32'(bus.busy_o), 32'h1);
            chk("all_cur", 32'(bus.cur_domain_o), 32'(i));
            wait_busy(1'b0, 60, nwait);
            chk("all_on_vec", 32'(bus.domain_on_o), 32'((1 << (i + 1)) - 1));
            chk("all_sw_vec", 32'(bus.switch_no), 32'(~((1 << (i + 1)) - 1) & 4'hF));
        end
        chk("all_iso", 32'(bus.iso_no), 32'hF);
        chk("all_err", 32'(bus.err_o),  32'h0);

        // Serve domain 1 (ptr=1), then 0 and 3 pending: 3 goes first
        bus.target_on_i = 4'b1101;
        wait_busy(1'b1, 10, nwait);
        chk("rr_cur1", 32'(bus.cur_domain_o), 32'd1);
        wait_busy(1'b0, 60, nwait);
        bus.target_on_i = 4'b0100;
        wait_busy(1'b1, 10, nwait);
        chk("rr_first3", 32'(bus.cur_domain_o), 32'd3);
        wait_busy(1'b0, 60, nwait);
        wait_busy(1'b1, 10, nwait);
        chk("rr_then0", 32'(bus.cur_domain_o), 32'd0);
        wait_busy(1'b0, 60, nwait);
        chk("rr_on_vec", 32'(bus.domain_on_o), 32'h4);
        chk("rr_sw_vec", 32'(bus.switch_no),   32'hB);

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
        // Ack stuck high: timeout after 64 cycles in PU_ACK, no re-grant until cleared
        rst = 1'b1;
        bus.target_on_i = 4'b0000;
        tick();
        rst = 1'b0;
        stuck = 4'b0001;
        bus.target_on_i = 4'b0001;
        watch(0, 120);
        chk("to_sw_fall", 32'(rel(t_sw)), 32'd1);
        chk("to_idle",    32'(rel(t_lo)), 32'd65);
        chk("to_err",     32'(bus.err_o), 32'h1);
        chk("to_sw_off",  32'(bus.switch_no[0]), 32'h1);
        chk("to_on",      32'(bus.domain_on_o), 32'h0);
        for (int k = 0; k < 20; k++) tick();
        chk("to_no_regrant", 32'(bus.busy_o), 32'h0);
        stuck = 4'b0000;
        bus.err_clr_i = 4'b0001;
        tick();
        bus.err_clr_i = 4'b0000;
        chk("to_err_clr", 32'(bus.err_o), 32'h0);
        tick();
        chk("to_regrant", 32'(bus.busy_o), 32'h1);
        wait_busy(1'b0, 60, nwait);
        chk("to_up_after_clr", 32'(bus.domain_on_o), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-away guard
    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_ext_power_sequencer
`default_nettype wire
